orb_frame_receiver: RTL and testbench
=====================================

# orb_frame_receiver

Receives one Orbita serial telemetry stream (any of the M16/M8/M4/M2/M1 group outputs), acquires frame synchronisation on a fixed 12-bit marker word and delivers de-serialised 12-bit words with their frame address. It is the consumer stage placed directly downstream of a frame former, in loopback checking and in receive-side test equipment. The surrounding clock divider supplies a one-cycle bit strobe, so the block runs on the fast system clock.

## Interface
- WORDS_PER_FRAME, 2048: words per frame, sync word included; 2..2048 (M16 = 2048, M8 = 1024, M4 = 512, M2 = 256, M1 = 128).
- SYNC_WORD, 12'hE25: marker pattern, word 0 of every frame, MSB first.
- CONFIRM, 2: consecutive correct markers required to enter LOCK; 1..7.
- LOSS_LIMIT, 3: consecutive bad markers that drop LOCK; 1..7.
- clk  in  1  system clock (clk100); one clock, no other domains.
- reset  in  1  synchronous, active-high reset.
- iBitEn  in  1  one-cycle strobe per serial bit period; iSerial is sampled only when high.
- iSerial  in  1  serial line, already synchronous to clk.
- oWord  out  12  received word, MSB = first bit on the line.
- oWordValid  out  1  one-cycle pulse, oWord/oAddr valid.
- oAddr  out  11  word index within frame, 0 = sync word.
- oFrameStart  out  1  one-cycle pulse coincident with oWordValid when oAddr = 0.
- oLocked  out  1  high in LOCK state.
- oSyncErrCnt  out  16  bad markers seen while locked, saturating.

## Operation
- Shift register sr[11:0]: on iBitEn, sr <= {sr[10:0], iSerial}.
- Bit counter bitCnt (0..11) and word counter wordCnt (0..WORDS_PER_FRAME-1) advance only on iBitEn.
- States:
  - HUNT: compare {sr[10:0], iSerial} with SYNC_WORD on every iBitEn. On match: bitCnt <= 0, wordCnt <= 1, goodCnt <= 1; go to VERIFY, or straight to LOCK if CONFIRM = 1. No word output.
  - VERIFY: word boundaries follow bitCnt. At each boundary with wordCnt = 0 (marker slot): match -> goodCnt+1, and LOCK when goodCnt reaches CONFIRM. Mismatch -> HUNT, goodCnt <= 0. No word output.
  - LOCK: every completed word -> oWord, oAddr = wordCnt, oWordValid pulse. Marker slot match -> badCnt <= 0. Mismatch -> badCnt+1, oSyncErrCnt+1 (saturates at 16'hFFFF). The word is still output with oAddr = 0. When badCnt reaches LOSS_LIMIT: go to HUNT, oLocked falls, no further words.
- wordCnt wraps from WORDS_PER_FRAME-1 to 0; wrap alone never changes state.
- On re-entry to HUNT from LOCK, the bit that completed the failing marker is already in sr. The hunt compare resumes on the next iBitEn.
- oSyncErrCnt clears only on reset.

## Timing
- Reset values: oWord = 0, oWordValid = 0, oAddr = 0, oFrameStart = 0, oLocked = 0, oSyncErrCnt = 0. Internally state = HUNT and all counters = 0.
- Reset mid-frame discards any partial word. The first iBitEn after reset deassertion is treated as bit 0 of the hunt.
- Latency: oWordValid asserts on the clk edge following the iBitEn cycle that carried the word's 12th bit (1 cycle). The pulse is exactly 1 cycle wide, whatever the iBitEn spacing.
- oLocked rises in the same cycle as the confirming boundary is registered; that marker word is itself output (oAddr = 0, oFrameStart = 1).
- Two iBitEn in consecutive cycles are legal (minimum spacing 1 clk). The bench must sustain iBitEn held high continuously.
- reset has priority over iBitEn in the same cycle.
- Not a handshake: there is no back-pressure. The consumer must accept every oWordValid.

## Test plan
- Reset: assert reset 3 cycles with iBitEn toggling -> all outputs 0, oLocked = 0.
- Clean acquisition: WORDS_PER_FRAME = 8, CONFIRM = 2. Feed 5 junk bits, then frames {E25, 001..007}, iBitEn every 8 clks.
  - oLocked rises at the second marker.
  - Words 001..007 then follow with oAddr 1..7; oFrameStart pulses on each later E25.
- False marker: place E25 at word 3 of a frame during HUNT -> VERIFY, then the next boundary (not a marker) -> HUNT. oLocked is never set.
- Loss of lock: LOSS_LIMIT = 3, locked. Corrupt 2 markers, then 1 good, then 3 bad.
  - oSyncErrCnt = 5.
  - oLocked falls right after the 3rd consecutive bad marker, with no oWordValid afterwards.
- Back-to-back bits: iBitEn held high, WORDS_PER_FRAME = 2048, 3 frames -> lock achieved. oAddr runs 0..2047 and wraps cleanly, and oWordValid appears every 12 cycles.
- Reset mid-word while locked: reset at bit 6 of word 100 -> outputs are 0 the next cycle and re-acquisition takes exactly CONFIRM markers.

Source files
------------

// File: rtl/orb_frame_receiver.sv
// Orbita telemetry frame receiver: hunts for the 12-bit marker, confirms it over
// CONFIRM frames, then delivers every de-serialised word with its frame address.
module orb_frame_receiver #(
  parameter int unsigned WORDS_PER_FRAME = 2048,
  parameter logic [11:0] SYNC_WORD       = 12'hE25,
  parameter int unsigned CONFIRM         = 2,
  parameter int unsigned LOSS_LIMIT      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iBitEn,
  input  logic        iSerial,
  output logic [11:0] oWord,
  output logic        oWordValid,
  output logic [10:0] oAddr,
  output logic        oFrameStart,
  output logic        oLocked,
  output logic [15:0] oSyncErrCnt
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_e;

  localparam logic [10:0] LAST_WORD = 11'(WORDS_PER_FRAME - 1);
  localparam logic [2:0]  CONFIRM_N = 3'(CONFIRM);
  localparam logic [2:0]  LOSS_N    = 3'(LOSS_LIMIT);

  state_e      state_q, state_d;
  logic [10:0] sr_q, sr_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] word_cnt_q, word_cnt_d;
  logic [2:0]  good_cnt_q, good_cnt_d;
  logic [2:0]  bad_cnt_q, bad_cnt_d;
  logic [11:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic [10:0] addr_q, addr_d;
  logic        fs_q, fs_d;
  logic        locked_q, locked_d;
  logic [15:0] err_q, err_d;

  logic [11:0] incoming;
  logic        match, boundary, marker_slot;
  logic [10:0] wc_next;
  logic [2:0]  good_inc, bad_inc;

  // Only the 11 newest bits are stored; the 12th is the bit on the line now.
  assign incoming    = {sr_q, iSerial};
  assign match       = (incoming == SYNC_WORD);
  assign boundary    = (bit_cnt_q == 4'd11);
  assign marker_slot = (word_cnt_q == '0);
  assign wc_next     = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 11'd1;
  assign good_inc    = good_cnt_q + 3'd1;
  assign bad_inc     = bad_cnt_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    addr_d     = addr_q;
    fs_d       = 1'b0;
    locked_d   = locked_q;
    err_d      = err_q;
    if (iBitEn) begin
      sr_d = incoming[10:0];
      unique case (state_q)
        HUNT: begin
          if (match) begin
            bit_cnt_d  = '0;
            word_cnt_d = 11'd1;
            good_cnt_d = 3'd1;
            // With CONFIRM = 1 this marker is the confirming one, so it is delivered.
            if (CONFIRM_N == 3'd1) begin
              state_d  = LOCK;
              locked_d = 1'b1;
              valid_d  = 1'b1;
              word_d   = incoming;
              addr_d   = '0;
              fs_d     = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          bit_cnt_d = boundary ? '0 : bit_cnt_q + 4'd1;
          if (boundary) begin
            word_cnt_d = wc_next;
            if (marker_slot) begin
              if (match) begin
                good_cnt_d = good_inc;
                if (good_inc == CONFIRM_N) begin
                  state_d  = LOCK;
                  locked_d = 1'b1;
                  valid_d  = 1'b1;
                  word_d   = incoming;
                  addr_d   = '0;
                  fs_d     = 1'b1;
                end
              end else begin
                state_d    = HUNT;
                good_cnt_d = '0;
              end
            end
          end
        end
        LOCK: begin
          bit_cnt_d = boundary ? '0 : bit_cnt_q + 4'd1;
          if (boundary) begin
            word_cnt_d = wc_next;
            valid_d    = 1'b1;
            word_d     = incoming;
            addr_d     = word_cnt_q;
            fs_d       = marker_slot;
            if (marker_slot) begin
              if (match) begin
                bad_cnt_d = '0;
              end else begin
                bad_cnt_d = bad_inc;
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                // The failing marker is still delivered; oLocked drops with it.
                if (bad_inc == LOSS_N) begin
                  state_d    = HUNT;
                  locked_d   = 1'b0;
                  bad_cnt_d  = '0;
                  good_cnt_d = '0;
                end
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      fs_q       <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      fs_q       <= fs_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign oWord       = word_q;
  assign oWordValid  = valid_q;
  assign oAddr       = addr_q;
  assign oFrameStart = fs_q;
  assign oLocked     = locked_q;
  assign oSyncErrCnt = err_q;

endmodule

// File: tb/tb_orb_frame_receiver.sv
// Scoreboard bench for orb_frame_receiver: an 8-word-frame instance for the
// acquisition/loss/reset scenarios and an M16 (2048-word) instance with iBitEn held high.
module tb_orb_frame_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en8, en2k, ser;

  logic [11:0] w8, w2k;
  logic        v8, v2k, fs8, fs2k, lk8, lk2k;
  logic [10:0] a8, a2k;
  logic [15:0] e8, e2k;

  orb_frame_receiver #(
    .WORDS_PER_FRAME(8), .SYNC_WORD(12'hE25), .CONFIRM(2), .LOSS_LIMIT(3)
  ) u_dut8 (
    .clk(clk), .reset(reset), .iBitEn(en8), .iSerial(ser),
    .oWord(w8), .oWordValid(v8), .oAddr(a8), .oFrameStart(fs8),
    .oLocked(lk8), .oSyncErrCnt(e8)
  );

  orb_frame_receiver #(
    .WORDS_PER_FRAME(2048), .SYNC_WORD(12'hE25), .CONFIRM(2), .LOSS_LIMIT(3)
  ) u_dut2k (
    .clk(clk), .reset(reset), .iBitEn(en2k), .iSerial(ser),
    .oWord(w2k), .oWordValid(v2k), .oAddr(a2k), .oFrameStart(fs2k),
    .oLocked(lk2k), .oSyncErrCnt(e2k)
  );

  typedef struct {
    logic [11:0] word;
    logic [10:0] addr;
    logic        fs;
    logic        locked;
    int unsigned cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q2k[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (v8 === 1'b1) begin
      chk_eq("dut8_word_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk_eq("dut8_word", w8, e.word);
        chk_eq("dut8_addr", a8, e.addr);
        chk_eq("dut8_framestart", fs8, e.fs);
        chk_eq("dut8_locked", lk8, e.locked);
        chk_eq("dut8_latency_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon2k
    exp_t e;
    if (v2k === 1'b1) begin
      chk_eq("dut2k_word_expected", 32'(q2k.size() != 0), 32'd1);
      if (q2k.size() != 0) begin
        e = q2k.pop_front();
        chk_eq("dut2k_word", w2k, e.word);
        chk_eq("dut2k_addr", a2k, e.addr);
        chk_eq("dut2k_framestart", fs2k, e.fs);
        chk_eq("dut2k_locked", lk2k, e.locked);
        chk_eq("dut2k_latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Drives one bit at a falling edge; spacing 1 keeps the strobe high continuously.
  task automatic send_bit(input bit sel2k, input logic b, input int unsigned sp);
    if (sel2k) en2k = 1'b1; else en8 = 1'b1;
    ser = b;
    @(negedge clk);
    if (sp > 1) begin
      en8  = 1'b0;
      en2k = 1'b0;
      repeat (sp - 1) @(negedge clk);
    end
  endtask

  task automatic send_word(input bit sel2k, input logic [11:0] w, input logic [10:0] a,
                           input bit expect_out, input bit exp_lock, input int unsigned sp);
    exp_t e;
    for (int i = 11; i >= 0; i--) begin
      if (i == 0 && expect_out) begin
        e.word   = w;
        e.addr   = a;
        e.fs     = (a == 11'd0);
        e.locked = exp_lock;
        e.cyc    = cyc + 1;
        if (sel2k) q2k.push_back(e); else q8.push_back(e);
      end
      send_bit(sel2k, w[i], sp);
    end
  endtask

  task automatic send_frame8(input logic [11:0] marker, input bit exp_m, input bit lock_m,
                             input bit exp_d, input int unsigned sp);
    send_word(1'b0, marker, 11'd0, exp_m, lock_m, sp);
    for (int k = 1; k < 8; k++) send_word(1'b0, 12'(k), 11'(k), exp_d, 1'b1, sp);
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    ser   = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      en8  = ~en8;
      en2k = ~en2k;
      @(negedge clk);
    end
    reset = 1'b0;
    en8   = 1'b0;
    en2k  = 1'b0;
  endtask

  task automatic chk_idle8(input string tag);
    chk_eq({tag, "_word"}, w8, 0);
    chk_eq({tag, "_valid"}, v8, 0);
    chk_eq({tag, "_addr"}, a8, 0);
    chk_eq({tag, "_framestart"}, fs8, 0);
    chk_eq({tag, "_locked"}, lk8, 0);
    chk_eq({tag, "_errcnt"}, e8, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en8   = 1'b0;
    en2k  = 1'b0;
    ser   = 1'b0;
    @(negedge clk);

    // Reset with the strobe toggling
    do_reset(3);
    chk_idle8("reset");
    chk_eq("reset_dut2k_locked", lk2k, 0);
    chk_eq("reset_dut2k_valid", v2k, 0);
    chk_eq("reset_dut2k_errcnt", e2k, 0);

    // Clean acquisition, strobe every 8 clocks
    repeat (5) send_bit(1'b0, 1'b0, 8);
    send_frame8(12'hE25, 1'b0, 1'b0, 1'b0, 8);
    chk_eq("acq_not_locked_after_first_marker", lk8, 0);
    send_frame8(12'hE25, 1'b1, 1'b1, 1'b1, 8);
    send_frame8(12'hE25, 1'b1, 1'b1, 1'b1, 8);
    chk_eq("acq_locked", lk8, 1);
    chk_eq("acq_errcnt", e8, 0);

    // False marker at word 3 of a frame while hunting
    do_reset(2);
    chk_idle8("reset2");
    for (int k = 0; k < 8; k++)
      send_word(1'b0, (k == 3) ? 12'hE25 : 12'(k), 11'(k), 1'b0, 1'b0, 3);
    send_frame8(12'hE25, 1'b0, 1'b0, 1'b0, 3);
    chk_eq("false_marker_not_locked", lk8, 0);
    send_frame8(12'hE25, 1'b0, 1'b0, 1'b0, 3);
    chk_eq("false_marker_still_unlocked", lk8, 0);
    send_frame8(12'hE25, 1'b1, 1'b1, 1'b1, 3);
    chk_eq("relock_after_false_marker", lk8, 1);

    // Loss of lock: 2 bad, 1 good, 3 bad markers
    send_frame8(12'hE24, 1'b1, 1'b1, 1'b1, 3);
    send_frame8(12'hE24, 1'b1, 1'b1, 1'b1, 3);
    chk_eq("loss_errcnt_after_two_bad", e8, 2);
    chk_eq("loss_still_locked", lk8, 1);
    send_frame8(12'hE25, 1'b1, 1'b1, 1'b1, 3);
    send_frame8(12'hE24, 1'b1, 1'b1, 1'b1, 3);
    send_frame8(12'hE24, 1'b1, 1'b1, 1'b1, 3);
    chk_eq("loss_locked_before_third_bad", lk8, 1);
    send_frame8(12'hE24, 1'b1, 1'b0, 1'b0, 3);
    chk_eq("loss_errcnt", e8, 5);
    chk_eq("loss_unlocked", lk8, 0);

    // Reset at bit 6 of word 5 while locked, then re-acquire
    send_frame8(12'hE25, 1'b0, 1'b0, 1'b0, 2);
    send_word(1'b0, 12'hE25, 11'd0, 1'b1, 1'b1, 2);
    for (int k = 1; k < 5; k++) send_word(1'b0, 12'(k), 11'(k), 1'b1, 1'b1, 2);
    chk_eq("midword_locked_before_reset", lk8, 1);
    for (int i = 11; i > 5; i--) send_bit(1'b0, 1'b0, 2);
    reset = 1'b1;
    en8   = 1'b1;
    ser   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    en8   = 1'b0;
    chk_idle8("midword_reset");
    send_frame8(12'hE25, 1'b0, 1'b0, 1'b0, 2);
    chk_eq("reacq_not_locked_after_one_marker", lk8, 0);
    send_frame8(12'hE25, 1'b1, 1'b1, 1'b1, 2);
    chk_eq("reacq_locked", lk8, 1);

    // M16 frames with iBitEn held high: lock, full address run, wrap
    send_word(1'b1, 12'hE25, 11'd0, 1'b0, 1'b0, 1);
    for (int k = 1; k < 2048; k++) send_word(1'b1, 12'(k), 11'(k), 1'b0, 1'b0, 1);
    send_word(1'b1, 12'hE25, 11'd0, 1'b1, 1'b1, 1);
    for (int k = 1; k < 2048; k++) send_word(1'b1, 12'(k), 11'(k), 1'b1, 1'b1, 1);
    send_word(1'b1, 12'hE25, 11'd0, 1'b1, 1'b1, 1);
    for (int k = 1; k < 4; k++) send_word(1'b1, 12'(k), 11'(k), 1'b1, 1'b1, 1);
    en2k = 1'b0;
    repeat (4) @(negedge clk);
    chk_eq("m16_locked", lk2k, 1);
    chk_eq("m16_errcnt", e2k, 0);

    repeat (4) @(negedge clk);
    chk_eq("dut8_scoreboard_drained", q8.size(), 0);
    chk_eq("dut2k_scoreboard_drained", q2k.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
